time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5, the number of minutes between snooze and re-ring (range 1-59).
REQ-002 SHALL have parameter RING_MAX_MIN, default 10, the number of minutes after which an unattended ring self-clears (range 1-59).
REQ-003 SHALL have port clk256, input, 1 bit: the 256 Hz system clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port one_minute, input, 1 bit: a single-clk256-cycle pulse from the seconds/minutes generator marking each minute.
REQ-006 SHALL have port load_time, input, 1 bit: a one-cycle strobe that loads set_value into the current time.
REQ-007 SHALL have port load_alarm, input, 1 bit: a one-cycle strobe that loads set_value into the alarm time.
REQ-008 SHALL have port set_value, input, 16 bits: BCD HH:MM as {h_tens[3:0], h_ones, m_tens, m_ones}.
REQ-009 SHALL have port alarm_en, input, 1 bit: a level that arms the alarm.
REQ-010 SHALL have ports snooze and stop, each input, 1 bit: one-cycle user strobes.
REQ-011 SHALL have port cur_time, output, 16 bits: the current time in BCD HH:MM, 24-hour.
REQ-012 SHALL have port alarm_time, output, 16 bits: the stored alarm time in BCD.
REQ-013 SHALL have port ringing, output, 1 bit: high while the alarm sounds.
REQ-014 SHALL have port load_err, output, 1 bit: a one-cycle pulse when a load is rejected.

Function
REQ-015 SHALL, on each one_minute pulse, increment cur_time by one minute with BCD carry: m_ones 9->0 carries into m_tens; m_tens 5->0 carries into hours; 09->10, 19->20, 23:59->00:00.
REQ-016 SHALL update all registers on the clk256 edge where the strobe is sampled, so outputs change 1 cycle after the strobe edge.
REQ-017 SHALL validate set_value on load: every digit <=9, m_tens <=5, hours <=23; invalid -> target register unchanged and load_err=1 for one cycle.
REQ-018 SHALL give load_time priority when it and one_minute coincide: the loaded value is taken and that minute tick is discarded.
REQ-019 SHALL service both loads in the same cycle if load_time and load_alarm coincide, each validated independently; load_err fires if either is rejected.
REQ-020 SHALL implement FSM states IDLE, RING, SNOOZED.
REQ-021 SHALL move IDLE->RING only on a one_minute increment whose new cur_time equals alarm_time while alarm_en=1; a load_time that lands on alarm_time SHALL NOT trigger.
REQ-022 SHALL, in RING, set ringing=1 and count minutes on a ring counter cleared on entry.
REQ-023 SHALL transition RING->IDLE on stop, or when the ring counter reaches RING_MAX_MIN.
REQ-024 SHALL transition RING->SNOOZED on snooze, clearing the snooze counter.
REQ-025 SHALL transition SNOOZED->RING when the snooze counter reaches SNOOZE_MIN, and SNOOZED->IDLE on stop.
REQ-026 SHALL give stop priority over snooze when both are asserted in the same cycle.
REQ-027 SHALL send any non-IDLE state to IDLE in the next cycle when alarm_en=0, with ringing=0 in that cycle.
REQ-028 SHALL ignore snooze while in IDLE or SNOOZED.
REQ-029 SHALL leave the FSM state unchanged on load_alarm; a new match is evaluated only from IDLE.
REQ-030 SHALL drive ringing as a registered output, high exactly when state=RING.

Reset
REQ-031 SHALL, on reset asserted (asynchronous), immediately set cur_time=16'h0000, alarm_time=16'h0000, state=IDLE, ringing=0, load_err=0, and all counters=0.
REQ-032 SHALL resume operation on the first clk256 edge after reset deasserts; a reset mid-ring SHALL silence ringing at once.

Verification
REQ-033 SHALL cover wrap: load 23:59 (16'h2359), one_minute pulse -> cur_time=16'h0000; load 09:59 then tick -> 16'h1000.
REQ-034 SHALL cover invalid load: load_time with 16'h2400, then 16'h1260 -> load_err pulses each, cur_time unchanged.
REQ-035 SHALL cover alarm: alarm 07:00, time 06:59, alarm_en=1, tick -> ringing=1 the next cycle; 10 more ticks -> ringing=0 (RING_MAX_MIN=10).
REQ-036 SHALL cover snooze: while ringing, snooze -> ringing=0; after 5 ticks -> ringing=1; stop+snooze together -> IDLE, ringing=0.
REQ-037 SHALL cover collision: load_time 12:00 coincident with one_minute -> cur_time=16'h1200, not 12:01; load_time equal to alarm_time -> no ring.
REQ-038 SHALL cover reset mid-ring: assert reset while ringing -> ringing=0 and cur_time=0 with no clock edge needed.

Source files
------------

// File: rtl/time_keeper.sv
// Alarm-clock core: BCD HH:MM timekeeping, validated time/alarm loads, and a
// ring/snooze FSM that runs off the one_minute pulse.
module time_keeper #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_MIN = 10
) (
    input  logic        clk256,
    input  logic        reset,
    input  logic        one_minute,
    input  logic        load_time,
    input  logic        load_alarm,
    input  logic [15:0] set_value,
    input  logic        alarm_en,
    input  logic        snooze,
    input  logic        stop,
    output logic [15:0] cur_time,
    output logic [15:0] alarm_time,
    output logic        ringing,
    output logic        load_err
);

    typedef enum logic [1:0] {IDLE, RING, SNOOZED} state_t;

    localparam logic [5:0] SNOOZE_LAST = 6'(SNOOZE_MIN - 1);
    localparam logic [5:0] RING_LAST   = 6'(RING_MAX_MIN - 1);

    state_t      state;
    logic [5:0]  ring_cnt;
    logic [5:0]  snooze_cnt;
    logic [15:0] next_minute;
    logic        set_valid;
    logic        tick;

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] ht, ho, mt, mo;
        {ht, ho, mt, mo} = t;
        if (mo != 4'd9) begin
            mo = mo + 4'd1;
        end else begin
            mo = 4'd0;
            if (mt != 4'd5) begin
                mt = mt + 4'd1;
            end else begin
                mt = 4'd0;
                if (ht == 4'd2 && ho == 4'd3) begin
                    ht = 4'd0;
                    ho = 4'd0;
                end else if (ho == 4'd9) begin
                    ho = 4'd0;
                    ht = ht + 4'd1;
                end else begin
                    ho = ho + 4'd1;
                end
            end
        end
        return {ht, ho, mt, mo};
    endfunction

    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) && (v[11:8] <= 4'd9) &&
               (v[15:12] <= 4'd2) && !(v[15:12] == 4'd2 && v[11:8] > 4'd3);
    endfunction

    // A load_time strobe swallows any coincident minute tick.
    assign tick        = one_minute && !load_time;
    assign next_minute = bcd_inc(cur_time);
    assign set_valid   = bcd_valid(set_value);

    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            cur_time   <= 16'h0000;
            alarm_time <= 16'h0000;
            load_err   <= 1'b0;
        end else begin
            if (load_time && set_valid) begin
                cur_time <= set_value;
            end else if (tick) begin
                cur_time <= next_minute;
            end
            if (load_alarm && set_valid) begin
                alarm_time <= set_value;
            end
            load_err <= (load_time || load_alarm) && !set_valid;
        end
    end

    // Only a real minute increment from IDLE can start a ring; ringing mirrors RING.
    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ringing    <= 1'b0;
            ring_cnt   <= 6'd0;
            snooze_cnt <= 6'd0;
        end else if (state != IDLE && !alarm_en) begin
            state   <= IDLE;
            ringing <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick && alarm_en && next_minute == alarm_time) begin
                        state    <= RING;
                        ringing  <= 1'b1;
                        ring_cnt <= 6'd0;
                    end
                end
                RING: begin
                    if (stop) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                    end else if (snooze) begin
                        state      <= SNOOZED;
                        ringing    <= 1'b0;
                        snooze_cnt <= 6'd0;
                    end else if (one_minute) begin
                        if (ring_cnt == RING_LAST) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 6'd1;
                        end
                    end
                end
                SNOOZED: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (one_minute) begin
                        if (snooze_cnt == SNOOZE_LAST) begin
                            state    <= RING;
                            ringing  <= 1'b1;
                            ring_cnt <= 6'd0;
                        end else begin
                            snooze_cnt <= snooze_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: wrap, invalid loads, alarm/ring timeout,
// snooze, load collisions and asynchronous reset while ringing.
module tb_time_keeper;

    logic        clk256 = 1'b0;
    logic        reset = 1'b1;
    logic        one_minute = 1'b0;
    logic        load_time = 1'b0;
    logic        load_alarm = 1'b0;
    logic [15:0] set_value = 16'h0000;
    logic        alarm_en = 1'b0;
    logic        snooze = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cur_time;
    logic [15:0] alarm_time;
    logic        ringing;
    logic        load_err;

    int checks = 0;
    int failures = 0;

    time_keeper #(.SNOOZE_MIN(5), .RING_MAX_MIN(10)) dut (
        .clk256(clk256), .reset(reset), .one_minute(one_minute),
        .load_time(load_time), .load_alarm(load_alarm), .set_value(set_value),
        .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
        .cur_time(cur_time), .alarm_time(alarm_time), .ringing(ringing),
        .load_err(load_err)
    );

    always #5 clk256 = ~clk256;

    // Drives strobes for one cycle; outputs are sampled on the following negedge.
    task automatic applyStimulus(input logic lt, input logic la, input logic om,
                                 input logic sn, input logic st, input logic [15:0] v);
        @(negedge clk256);
        load_time = lt; load_alarm = la; one_minute = om;
        snooze = sn; stop = st; set_value = v;
        @(negedge clk256);
        load_time = 1'b0; load_alarm = 1'b0; one_minute = 1'b0;
        snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk256);
        checks++; if (cur_time !== 16'h0000) begin failures++; $display("[TB] FAIL reset_cur_time got=%h exp=0000", cur_time); end
        checks++; if (alarm_time !== 16'h0000) begin failures++; $display("[TB] FAIL reset_alarm_time got=%h exp=0000", alarm_time); end
        checks++; if (ringing !== 1'b0) begin failures++; $display("[TB] FAIL reset_ringing got=%b exp=0", ringing); end
        checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_err got=%b exp=0", load_err); end
        reset = 1'b0;
    endtask

    task automatic test_wrap;
        logic [15:0] loads[5] = '{16'h2359, 16'h0959, 16'h1959, 16'h1249, 16'h1205};
        logic [15:0] exps[5]  = '{16'h0000, 16'h1000, 16'h2000, 16'h1250, 16'h1206};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0, loads[i]);
            checks++; if (cur_time !== loads[i] || load_err !== 1'b0) begin failures++; $display("[TB] FAIL wrap_load got=%h err=%b exp=%h err=0", cur_time, load_err, loads[i]); end
            applyStimulus(0, 0, 1, 0, 0, 16'h0000);
            checks++; if (cur_time !== exps[i]) begin failures++; $display("[TB] FAIL wrap_tick got=%h exp=%h", cur_time, exps[i]); end
        end
    endtask

    task automatic test_invalid;
        applyStimulus(1, 0, 0, 0, 0, 16'h1234);
        applyStimulus(1, 0, 0, 0, 0, 16'h2400);
        checks++; if (load_err !== 1'b1 || cur_time !== 16'h1234) begin failures++; $display("[TB] FAIL invalid_2400 err=%b time=%h exp err=1 time=1234", load_err, cur_time); end
        @(negedge clk256);
        checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL invalid_err_one_cycle got=%b exp=0", load_err); end
        applyStimulus(1, 0, 0, 0, 0, 16'h1260);
        checks++; if (load_err !== 1'b1 || cur_time !== 16'h1234) begin failures++; $display("[TB] FAIL invalid_1260 err=%b time=%h exp err=1 time=1234", load_err, cur_time); end
        applyStimulus(1, 0, 0, 0, 0, 16'h1A00);
        checks++; if (load_err !== 1'b1 || cur_time !== 16'h1234) begin failures++; $display("[TB] FAIL invalid_1A00 err=%b time=%h exp err=1 time=1234", load_err, cur_time); end
        applyStimulus(0, 1, 0, 0, 0, 16'h0970);
        checks++; if (load_err !== 1'b1 || alarm_time !== 16'h0000) begin failures++; $display("[TB] FAIL invalid_alarm err=%b alarm=%h exp err=1 alarm=0000", load_err, alarm_time); end
    endtask

    task automatic test_alarm;
        alarm_en = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 16'h0700);
        checks++; if (alarm_time !== 16'h0700 || load_err !== 1'b0) begin failures++; $display("[TB] FAIL alarm_load got=%h err=%b exp=0700 err=0", alarm_time, load_err); end
        applyStimulus(1, 0, 0, 0, 0, 16'h0659);
        checks++; if (ringing !== 1'b0) begin failures++; $display("[TB] FAIL alarm_pre got=%b exp=0", ringing); end
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b1 || cur_time !== 16'h0700) begin failures++; $display("[TB] FAIL alarm_ring ring=%b time=%h exp ring=1 time=0700", ringing, cur_time); end
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b1) begin failures++; $display("[TB] FAIL alarm_ring_9min got=%b exp=1", ringing); end
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b0 || cur_time !== 16'h0710) begin failures++; $display("[TB] FAIL alarm_timeout ring=%b time=%h exp ring=0 time=0710", ringing, cur_time); end
    endtask

    task automatic test_snooze;
        applyStimulus(1, 0, 0, 0, 0, 16'h0659);
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b1) begin failures++; $display("[TB] FAIL snooze_ring got=%b exp=1", ringing); end
        applyStimulus(0, 0, 0, 1, 0, 16'h0000);
        checks++; if (ringing !== 1'b0) begin failures++; $display("[TB] FAIL snooze_silence got=%b exp=0", ringing); end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b0) begin failures++; $display("[TB] FAIL snooze_4min got=%b exp=0", ringing); end
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b1) begin failures++; $display("[TB] FAIL snooze_rering got=%b exp=1", ringing); end
        applyStimulus(0, 0, 0, 1, 1, 16'h0000);
        checks++; if (ringing !== 1'b0) begin failures++; $display("[TB] FAIL stop_snooze got=%b exp=0", ringing); end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b0 || cur_time !== 16'h0711) begin failures++; $display("[TB] FAIL stop_is_idle ring=%b time=%h exp ring=0 time=0711", ringing, cur_time); end
    endtask

    task automatic test_disable;
        applyStimulus(1, 0, 0, 0, 0, 16'h0659);
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b1) begin failures++; $display("[TB] FAIL disable_pre got=%b exp=1", ringing); end
        @(negedge clk256);
        alarm_en = 1'b0;
        @(negedge clk256);
        alarm_en = 1'b1;
        checks++; if (ringing !== 1'b0) begin failures++; $display("[TB] FAIL disable_silence got=%b exp=0", ringing); end
        @(negedge clk256);
        checks++; if (ringing !== 1'b0) begin failures++; $display("[TB] FAIL disable_stays_idle got=%b exp=0", ringing); end
    endtask

    task automatic test_collision;
        applyStimulus(1, 0, 1, 0, 0, 16'h1200);
        checks++; if (cur_time !== 16'h1200) begin failures++; $display("[TB] FAIL collide_load_tick got=%h exp=1200", cur_time); end
        applyStimulus(1, 0, 0, 0, 0, 16'h0700);
        @(negedge clk256);
        checks++; if (ringing !== 1'b0 || cur_time !== 16'h0700) begin failures++; $display("[TB] FAIL load_on_alarm ring=%b time=%h exp ring=0 time=0700", ringing, cur_time); end
        applyStimulus(1, 1, 0, 0, 0, 16'h1530);
        checks++; if (cur_time !== 16'h1530 || alarm_time !== 16'h1530 || load_err !== 1'b0) begin failures++; $display("[TB] FAIL dual_load time=%h alarm=%h err=%b exp 1530 1530 0", cur_time, alarm_time, load_err); end
        applyStimulus(1, 1, 0, 0, 0, 16'h2500);
        checks++; if (cur_time !== 16'h1530 || alarm_time !== 16'h1530 || load_err !== 1'b1) begin failures++; $display("[TB] FAIL dual_bad time=%h alarm=%h err=%b exp 1530 1530 1", cur_time, alarm_time, load_err); end
    endtask

    task automatic test_reset_mid_ring;
        applyStimulus(0, 1, 0, 0, 0, 16'h0700);
        applyStimulus(1, 0, 0, 0, 0, 16'h0659);
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (ringing !== 1'b1) begin failures++; $display("[TB] FAIL midring_pre got=%b exp=1", ringing); end
        reset = 1'b1;
        #1;
        checks++; if (ringing !== 1'b0 || cur_time !== 16'h0000) begin failures++; $display("[TB] FAIL midring_async ring=%b time=%h exp ring=0 time=0000", ringing, cur_time); end
        @(negedge clk256);
        reset = 1'b0;
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        checks++; if (cur_time !== 16'h0001 || ringing !== 1'b0) begin failures++; $display("[TB] FAIL post_reset time=%h ring=%b exp time=0001 ring=0", cur_time, ringing); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_invalid();
        test_alarm();
        test_snooze();
        test_disable();
        test_collision();
        test_reset_mid_ring();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
